// File: rtl/mem_pkg.sv
// Shared types and helpers for the parametrised memory bank.
package mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic int unsigned byte_lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_bank_array.sv
// Raw DEPTH x DATA_W storage: per-byte write enables and a registered read port.
module mem_bank_array
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int unsigned LANES = byte_lanes(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Caller guarantees addr < DEPTH whenever wr_be or rd_en is active.
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (wr_be[i]) begin
        mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/memory_bank.sv
// Single-port memory bank: post-reset clear, byte-enabled writes, valid/ready
// request handshake with response backpressure and out-of-range read flagging.
module memory_bank
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DEPTH          = 2**ADDR_W,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic                REQ_RW,
  input  logic [ADDR_W-1:0]   REQ_ADDR,
  input  logic [DATA_W-1:0]   REQ_DIN,
  input  logic [DATA_W/8-1:0] REQ_BE,
  output logic                RSP_VALID,
  input  logic                RSP_READY,
  output logic [DATA_W-1:0]   RSP_DOUT,
  output logic                RSP_ERR,
  output logic                BUSY
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     clr_ptr_q, clr_ptr_d;
  logic                rsp_valid_q, rsp_err_q;
  logic                in_range, accept;
  logic [ADDR_W-1:0]   arr_addr;
  logic [DATA_W/8-1:0] arr_be;
  logic [DATA_W-1:0]   arr_din, arr_dout;
  logic                arr_rd_en;

  always_comb begin
    in_range  = ({1'b0, REQ_ADDR} < DEPTH_L);
    REQ_READY = (state_q == RUN) && (!rsp_valid_q || RSP_READY);
    accept    = REQ_VALID && REQ_READY;
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    arr_addr  = REQ_ADDR;
    arr_be    = '0;
    arr_din   = REQ_DIN;
    arr_rd_en = 1'b0;
    BUSY      = 1'b0;
    unique case (state_q)
      CLEAR: begin
        BUSY      = 1'b1;
        arr_addr  = clr_ptr_q[ADDR_W-1:0];
        arr_be    = '1;
        arr_din   = '0;
        clr_ptr_d = clr_ptr_q + ONE_L;
        if (clr_ptr_q == LAST_L) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Out-of-range requests are accepted but never reach storage.
        if (accept && in_range) begin
          if (REQ_RW) begin
            arr_be = REQ_BE;
          end else begin
            arr_rd_en = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (!RESET) begin
      arr_be = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_ptr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      if (accept && !REQ_RW) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= !in_range;
      end else if (RSP_READY) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  mem_bank_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .CLK     (CLK),
    .RESET   (RESET),
    .addr    (arr_addr),
    .wr_be   (arr_be),
    .wr_data (arr_din),
    .rd_en   (arr_rd_en),
    .rd_data (arr_dout)
  );

  // The array only captures in-range reads, so the error flag forces zero data.
  always_comb begin
    RSP_VALID = rsp_valid_q;
    RSP_ERR   = rsp_err_q;
    RSP_DOUT  = rsp_err_q ? '0 : arr_dout;
  end

endmodule

// File: doc/memory_bank.md
Name: memory_bank

Overview:
- Parametrised single-port synchronous memory bank. Successor to the team's fixed 256x32 memory.
- Adds configurable width and depth, per-byte write enables, and a valid/ready request/response handshake with response backpressure.
- Clears its contents sequentially after reset, and flags out-of-range accesses.
- Sits between a bus master (core or test driver) and on-chip storage.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 8, address width in bits.
- DEPTH, 2**ADDR_W, number of implemented words; 1 <= DEPTH <= 2**ADDR_W.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = contents left unchanged.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  synchronous, active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  bank can accept a request this cycle.
- REQ_RW  in  1  1 = write, 0 = read.
- REQ_ADDR  in  ADDR_W  word address.
- REQ_DIN  in  DATA_W  write data.
- REQ_BE  in  DATA_W/8  byte write enables; bit i covers bits [8i+7:8i].
- RSP_VALID  out  1  read response present.
- RSP_READY  in  1  consumer accepts the response.
- RSP_DOUT  out  DATA_W  read data.
- RSP_ERR  out  1  response belongs to an out-of-range read.
- BUSY  out  1  clear sequence in progress.

Behaviour:
- States: CLEAR, RUN.
- Reset (RESET==0 at a posedge):
  - state <= CLEAR if CLEAR_ON_RESET, else RUN.
  - clr_ptr <= 0.
  - RSP_VALID, RSP_ERR <= 0; RSP_DOUT <= 0.
- CLEAR:
  - One word per cycle: mem[clr_ptr] <= 0, clr_ptr++.
  - After writing word DEPTH-1, go to RUN; the clear takes exactly DEPTH cycles after reset release.
  - BUSY = 1 and REQ_READY = 0 throughout.
- RUN: BUSY = 0.
- REQ_READY = (state==RUN) && (!RSP_VALID || RSP_READY). It is combinational and identical for reads and writes.
- Accept = REQ_VALID && REQ_READY at a posedge.
- Accepted write:
  - For each i with REQ_BE[i]==1, byte i of mem[REQ_ADDR] is updated at that edge. Other bytes are unchanged.
  - Writes produce no response.
  - REQ_BE==0 is a legal no-op.
- Accepted read:
  - RSP_DOUT <= mem[REQ_ADDR] and RSP_VALID <= 1 at that edge (1-cycle latency).
  - A read accepted the cycle after a write to the same address returns the new data.
- Response hold:
  - While RSP_VALID && !RSP_READY, RSP_DOUT and RSP_ERR stay stable and no request is accepted.
  - RSP_VALID && RSP_READY with no new read: RSP_VALID <= 0 next edge. RSP_DOUT keeps its last value.
  - RSP_VALID && RSP_READY plus a new read: RSP_VALID stays 1 with the new data. Full throughput is one read per cycle.
- Out of range (REQ_ADDR >= DEPTH):
  - Write is accepted and dropped; no storage changes.
  - Read is accepted and returns RSP_DOUT = 0 with RSP_ERR = 1. RSP_ERR = 0 for in-range reads.
- Reset mid-clear: clear restarts from word 0.
- Reset with a pending response: the response is discarded (RSP_VALID drops on that edge).
- REQ_* ignored while REQ_READY==0; inputs may change freely then.
- clr_ptr width is ADDR_W+1 so that DEPTH==2**ADDR_W terminates without wrap ambiguity.

Decomposition:
- Shared package mem_pkg: state enum {CLEAR, RUN}; helper function for byte-lane count (DATA_W/8).
- One natural sub-module: mem_bank_array, the raw DEPTH x DATA_W storage with per-byte write enables and a registered read.
- memory_bank owns the FSM, clear pointer, handshake and range check.

Test Plan:
- Clear timing: drive RESET=0 for 2 cycles, then 1 (DEPTH=256) -> BUSY=1 and REQ_READY=0 for exactly 256 cycles, then REQ_READY=1; reading addresses 0, 128 and 255 returns 0x00000000.
- Full write/read: write 0xACBD4432 to addr 0 with BE=4'hF, then read addr 0 -> RSP_VALID=1 one cycle after accept, RSP_DOUT=0xACBD4432, RSP_ERR=0.
- Byte enables: after the scenario above, write 0xDFD6BB42 to addr 0 with BE=4'b0101 -> read returns 0xACD64442.
- Backpressure:
  - Stimulus: read addr 0 with RSP_READY=0 for 5 cycles while REQ_VALID stays high for a read of addr 4 (holding 0x11223344).
  - Required: RSP_DOUT holds 0xACD64442 and REQ_READY=0 for those 5 cycles; after RSP_READY=1, the next response is 0x11223344 on the following cycle.
- Out of range (DEPTH=200, ADDR_W=8):
  - Write 0xFFFFFFFF to addr 250 -> no storage change.
  - Read addr 250 -> RSP_DOUT=0, RSP_ERR=1.
  - Read addr 199 -> RSP_ERR=0.
- Reset mid-operation:
  - Assert RESET=0 at clear cycle 100 -> clear restarts; total BUSY after release = 256 cycles.
  - Assert RESET=0 while RSP_VALID=1 -> RSP_VALID=0 after that edge.
